// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-stage bundle: PC/halt/stall/load inputs and fetched-word outputs
interface instr_fetch_if #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
);
    logic               start;
    logic [ADDR_W-1:0]  PC;
    logic               halt_in;
    logic               stall;
    logic               load_en;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic [INSTR_W-1:0] instruction;
    logic               instr_valid;
    logic [ADDR_W-1:0]  fetch_addr;
    logic [CNT_W-1:0]   instr_count;
    logic               busy;
    logic               done;

    modport master (
        output start, PC, halt_in, stall, load_en, load_addr, load_data,
        input  instruction, instr_valid, fetch_addr, instr_count, busy, done
    );

    modport slave (
        input  start, PC, halt_in, stall, load_en, load_addr, load_data,
        output instruction, instr_valid, fetch_addr, instr_count, busy, done
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with loadable program memory, stall hold and halt drain
module instr_fetch #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 9,
    parameter int CNT_W   = 16
) (
    input  logic         CLK,
    input  logic         init_n,
    instr_fetch_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]         state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  faddr_q, faddr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [INSTR_W-1:0] mem [DEPTH];
    logic               loadable;
    logic               mem_we;
    logic [INSTR_W-1:0] rd_word;

    // Program memory is writable only while no fetch is in flight.
    assign loadable = (state_q == S_IDLE) || (state_q == S_HALTED);
    assign mem_we   = loadable && bus.load_en;
    assign rd_word  = mem[bus.PC];

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        valid_d = valid_q;
        faddr_d = faddr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                valid_d = 1'b0;
                if (bus.start) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                end
            end
            S_FETCH: begin
                // Halt wins over stall so a stalled pipe can still be stopped.
                if (bus.halt_in) begin
                    state_d = S_DRAIN;
                    valid_d = 1'b0;
                end else if (!bus.stall) begin
                    instr_d = rd_word;
                    faddr_d = bus.PC;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            S_DRAIN: begin
                state_d = S_HALTED;
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            valid_q <= 1'b0;
            faddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            faddr_q <= faddr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.fetch_addr  = faddr_q;
    assign bus.instr_count = cnt_q;
    assign bus.busy        = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign bus.done        = (state_q == S_HALTED);
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;
    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 9;
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  addr;
        logic [CNT_W-1:0]   cnt;
    } exp_t;

    logic CLK = 1'b0;
    logic init_n = 1'b0;
    always #5 CLK = ~CLK;

    instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();
    instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .init_n(init_n), .bus(bus)
    );

    instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(3)) sbus ();
    instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(3)) dut_small (
        .CLK(CLK), .init_n(init_n), .bus(sbus)
    );

    int total = 0;
    int bad = 0;
    exp_t sb[$];
    exp_t e;
    exp_t obs;
    logic [INSTR_W-1:0] model_mem [1024];
    logic [CNT_W-1:0] exp_cnt;

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic push_fetch(input logic [ADDR_W-1:0] pc);
        bus.PC = pc;
        exp_cnt = exp_cnt + 1'b1;
        sb.push_back({model_mem[pc], pc, exp_cnt});
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
        bus.load_en = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        model_mem[a] = d;
        tick();
        bus.load_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        total++;
        if ({bus.instruction, bus.instr_valid, bus.fetch_addr, bus.instr_count, bus.busy, bus.done} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got instr=%h v=%b addr=%h cnt=%0d busy=%b done=%b want all zero",
                     bus.instruction, bus.instr_valid, bus.fetch_addr, bus.instr_count, bus.busy, bus.done);
        end
        init_n = 1'b1;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_fetch();
        load_word(10'd0, 9'h041);
        load_word(10'd1, 9'h012);
        load_word(10'd2, 9'h1FF);
        load_word(10'd3, 9'h000);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_cnt = '0;
        total++;
        if (bus.busy !== 1'b1 || bus.instr_count !== 16'd0 || bus.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL fetch_enter got busy=%b cnt=%0d v=%b want 1 0 0", bus.busy, bus.instr_count, bus.instr_valid);
        end
        for (int i = 0; i < 4; i++) begin
            push_fetch(ADDR_W'(i));
            tick();
            e = sb.pop_front();
            obs = {bus.instruction, bus.fetch_addr, bus.instr_count};
            total++;
            if (obs !== e || bus.instr_valid !== 1'b1) begin
                bad++;
                $display("FAIL fetch_seq[%0d] got %h/%h/%0d v=%b want %h/%h/%0d v=1",
                         i, obs.instr, obs.addr, obs.cnt, bus.instr_valid, e.instr, e.addr, e.cnt);
            end
        end
    endtask

    task automatic test_stall();
        push_fetch(10'd1);
        tick();
        e = sb.pop_front();
        obs = {bus.instruction, bus.fetch_addr, bus.instr_count};
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL stall_pre got %h/%h/%0d want %h/%h/%0d", obs.instr, obs.addr, obs.cnt, e.instr, e.addr, e.cnt);
        end
        bus.stall = 1'b1;
        bus.PC = 10'd2;
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {bus.instruction, bus.fetch_addr, bus.instr_count};
            total++;
            if (obs !== e || bus.instr_valid !== 1'b1) begin
                bad++;
                $display("FAIL stall_hold[%0d] got %h/%h/%0d want %h/%h/%0d",
                         i, obs.instr, obs.addr, obs.cnt, e.instr, e.addr, e.cnt);
            end
        end
        bus.stall = 1'b0;
        push_fetch(10'd2);
        tick();
        e = sb.pop_front();
        obs = {bus.instruction, bus.fetch_addr, bus.instr_count};
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL stall_resume got %h/%h/%0d want %h/%h/%0d", obs.instr, obs.addr, obs.cnt, e.instr, e.addr, e.cnt);
        end
    endtask

    task automatic test_halt();
        bus.halt_in = 1'b1;
        bus.stall = 1'b1;
        bus.PC = 10'd3;
        tick();
        bus.halt_in = 1'b0;
        bus.stall = 1'b0;
        total++;
        if (bus.instr_valid !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.instr_count !== exp_cnt) begin
            bad++;
            $display("FAIL halt_drain got v=%b busy=%b done=%b cnt=%0d want 0 1 0 %0d",
                     bus.instr_valid, bus.busy, bus.done, bus.instr_count, exp_cnt);
        end
        tick();
        total++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.instr_valid !== 1'b0) begin
            bad++;
            $display("FAIL halt_state got done=%b busy=%b v=%b want 1 0 0", bus.done, bus.busy, bus.instr_valid);
        end
        tick();
        total++;
        if (bus.instruction !== e.instr || bus.fetch_addr !== e.addr || bus.done !== 1'b1) begin
            bad++;
            $display("FAIL halt_hold got %h/%h done=%b want %h/%h done=1", bus.instruction, bus.fetch_addr, bus.done, e.instr, e.addr);
        end
    endtask

    task automatic test_halted_load();
        bus.load_en = 1'b1;
        bus.load_addr = 10'd5;
        bus.load_data = 9'h0AA;
        model_mem[5] = 9'h0AA;
        bus.start = 1'b1;
        tick();
        bus.load_en = 1'b0;
        bus.start = 1'b0;
        exp_cnt = '0;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.instr_count !== 16'd0) begin
            bad++;
            $display("FAIL restart got done=%b busy=%b cnt=%0d want 0 1 0", bus.done, bus.busy, bus.instr_count);
        end
        push_fetch(10'd5);
        tick();
        e = sb.pop_front();
        obs = {bus.instruction, bus.fetch_addr, bus.instr_count};
        total++;
        if (obs !== e || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL halted_load got %h/%h/%0d done=%b want %h/%h/%0d done=0",
                     obs.instr, obs.addr, obs.cnt, bus.done, e.instr, e.addr, e.cnt);
        end
    endtask

    task automatic test_fetch_load_ignored();
        bus.load_en = 1'b1;
        bus.load_addr = 10'd0;
        bus.load_data = 9'h155;
        push_fetch(10'd3);
        tick();
        bus.load_en = 1'b0;
        e = sb.pop_front();
        obs = {bus.instruction, bus.fetch_addr, bus.instr_count};
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL fetch_load_cycle got %h/%h/%0d want %h/%h/%0d", obs.instr, obs.addr, obs.cnt, e.instr, e.addr, e.cnt);
        end
        push_fetch(10'd0);
        tick();
        e = sb.pop_front();
        obs = {bus.instruction, bus.fetch_addr, bus.instr_count};
        total++;
        if (obs !== e || obs.instr !== 9'h041) begin
            bad++;
            $display("FAIL fetch_load_ignored got %h/%h/%0d want %h/%h/%0d", obs.instr, obs.addr, obs.cnt, e.instr, e.addr, e.cnt);
        end
    endtask

    task automatic test_async_reset();
        bus.PC = 10'd2;
        #2;
        init_n = 1'b0;
        #1;
        total++;
        if ({bus.instruction, bus.instr_valid, bus.fetch_addr, bus.instr_count, bus.busy, bus.done} !== '0) begin
            bad++;
            $display("FAIL async_reset got instr=%h v=%b addr=%h cnt=%0d busy=%b done=%b want all zero",
                     bus.instruction, bus.instr_valid, bus.fetch_addr, bus.instr_count, bus.busy, bus.done);
        end
        @(negedge CLK);
        init_n = 1'b1;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_cnt = '0;
        push_fetch(10'd5);
        tick();
        push_fetch(10'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            if (i == 1) begin
                obs = {bus.instruction, bus.fetch_addr, bus.instr_count};
                total++;
                if (obs !== e) begin
                    bad++;
                    $display("FAIL mem_retained got %h/%h/%0d want %h/%h/%0d", obs.instr, obs.addr, obs.cnt, e.instr, e.addr, e.cnt);
                end
            end
        end
    endtask

    task automatic test_count_wrap();
        logic [2:0] want;
        sbus.start = 1'b1;
        tick();
        sbus.start = 1'b0;
        sbus.PC = 10'd0;
        want = 3'd0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            want = want + 3'd1;
            total++;
            if (sbus.instr_count !== want) begin
                bad++;
                $display("FAIL count_wrap[%0d] got %0d want %0d", i, sbus.instr_count, want);
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.PC = '0; bus.halt_in = 1'b0; bus.stall = 1'b0;
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        sbus.start = 1'b0; sbus.PC = '0; sbus.halt_in = 1'b0; sbus.stall = 1'b0;
        sbus.load_en = 1'b0; sbus.load_addr = '0; sbus.load_data = '0;
        exp_cnt = '0;
        for (int i = 0; i < 1024; i++) model_mem[i] = '0;
        test_reset();
        test_fetch();
        test_stall();
        test_halt();
        test_halted_load();
        test_fetch_load_ignored();
        test_async_reset();
        test_count_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
